// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [WORD_W-1:0] PC_READ_OFFSET = 32'd8;

    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instruction, pc} entries with synchronous flush; flush wins over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    fetch_entry_t  storage [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited imem requests, prefetch queue and branch redirect.
// Optional FETCH_BYPASS_EN presents a response straight to the output when the queue is empty.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus8
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    fetch_entry_t  q_head;
    fetch_entry_t  q_in;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;

    logic          req_fire;
    logic          resp_live;
    logic          bypass_hit;
    logic          dequeue;
    logic [CW:0]   credit_used;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_live = imem_resp_valid && (drop == '0) && !branch_taken;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_live && q_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign instr_valid = !q_empty || bypass_hit;
    assign dequeue     = instr_valid && !stall;
    assign q_pop       = dequeue && !q_empty;
    // A bypassed word that is consumed immediately never needs a queue slot.
    assign q_push      = resp_live && !(bypass_hit && !stall);
    assign q_in        = '{instruction: imem_resp_data, pc: resp_pc};

    // Words already buffered plus words still owed by memory must fit the queue.
    assign credit_used    = {1'b0, q_count} + {1'b0, outstanding} - (CW+1)'(dequeue);
    assign imem_req_valid = !reset && !branch_taken && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        instruction = '0;
        instr_pc    = resp_pc;
        if (!q_empty) begin
            instruction = q_head.instruction;
            instr_pc    = q_head.pc;
        end else if (bypass_hit) begin
            instruction = imem_resp_data;
        end
    end

    assign instr_pc_plus8 = instr_pc + PC_READ_OFFSET;

    // NOTE: non-blocking assignments so every register here updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (branch_taken) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc    <= align_word(branch_target);
            resp_pc     <= align_word(branch_target);
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop        <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (imem_resp_valid) begin
                if (drop != '0) drop <= drop - 1'b1;
                else            resp_pc <= resp_pc + PC_STEP;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (q_push),
        .push_data(q_in),
        .pop      (q_pop),
        .flush    (branch_taken),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: memory model with fixed latency and epoch-tagged responses.
module tb_instruction_fetch;

    localparam int          QD       = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID_CYCLE = 2;
`else
    localparam int FIRST_VALID_CYCLE = 3;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_entry_t;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus8;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          epoch    = 0;
    logic        stale_resp = 1'b0;
    logic [31:0] exp_fetch  = RESET_PC;
    sb_entry_t   sb[$];
    mem_entry_t  mem_q[$];

    instruction_fetch #(
        .QUEUE_DEPTH(QD),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_pc_plus8 (instr_pc_plus8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, ~addr[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory: answers accepted requests in order, exactly lat cycles later.
    always @(posedge clock) begin
        mem_entry_t m;
        cyc++;
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        stale_resp      = 1'b0;
        if (!reset && mem_q.size() > 0 && mem_q[0].due == cyc) begin
            m = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(m.addr);
            if (m.epoch == epoch) sb.push_back('{pc: m.addr, data: mem_word(m.addr)});
            else                  stale_resp = 1'b1;
        end
    end

    // Monitor: compares presented instructions against the scoreboard and tracks fetch order.
    always @(negedge clock) begin
        int occ;
        int inflight;
        int deq;
        if (reset) begin
            sb.delete();
            mem_q.delete();
            exp_fetch = RESET_PC;
            epoch++;
        end else begin
            occ      = sb.size();
            inflight = mem_q.size() + int'(stale_resp);
            deq      = int'(instr_valid && !stall);
            if (instr_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(instr_valid), 32'd0);
                end else begin
                    check("instr_pc", instr_pc, sb[0].pc);
                    check("instruction", instruction, sb[0].data);
                    check("pc_plus8", instr_pc_plus8, sb[0].pc + 32'd8);
                    if (deq != 0) void'(sb.pop_front());
                end
            end else begin
                check("idle_instruction", instruction, 32'd0);
            end
            if (imem_req_valid) check("credit", 32'((occ + inflight - deq) < QD), 32'd1);
            if (branch_taken)   check("req_in_redirect", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_fetch);
                mem_q.push_back('{addr: exp_fetch, due: cyc + lat, epoch: epoch});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (branch_taken) begin
                sb.delete();
                epoch++;
                exp_fetch = branch_target & ~32'd3;
            end
        end
    end

    task automatic apply_reset();
        reset          = 1'b1;
        branch_taken   = 1'b0;
        branch_target  = '0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        @(negedge clock);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_pc_plus8", instr_pc_plus8, RESET_PC + 32'd8);
        tick();
    endtask

    task automatic wait_valid(input string tag, output bit seen);
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (instr_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int first;
        bit seen;
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        branch_taken    = 1'b0;
        branch_target   = '0;
        stall           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;

        // Startup latency and one-per-cycle streaming with L=1.
        apply_reset();
        lat   = 1;
        reset = 1'b0;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (instr_valid) begin
                first = n;
                break;
            end
        end
        check("first_valid_cycle", 32'(first), 32'(FIRST_VALID_CYCLE));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_pc", instr_pc, 32'(i * 4));
            check("stream_plus8", instr_pc_plus8, 32'(i * 4 + 8));
        end

        // Downstream stall for five cycles, then resume.
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_hold", 32'(instr_valid), 32'd1);
            tick();
        end
        stall = 1'b0;
        repeat (10) tick();

        // Memory not ready for three cycles while 0x10 is requested.
        apply_reset();
        lat   = 1;
        reset = 1'b0;
        seen  = 0;
        for (int n = 0; n < 30; n++) begin
            if (imem_req_valid && imem_req_addr == 32'h10) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check("reach_0x10", 32'd0, 32'd1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("ready_low_valid", 32'(imem_req_valid), 32'd1);
            check("ready_low_addr", imem_req_addr, 32'h10);
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (8) tick();

        // L=3, two requests in flight, redirect to an unaligned target.
        apply_reset();
        lat   = 3;
        reset = 1'b0;
        tick();
        tick();
        check("inflight_at_branch", 32'(mem_q.size()), 32'd2);
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        wait_valid("timeout_branch_l3", seen);
        if (seen) begin
            check("target_pc", instr_pc, 32'h100);
            check("target_word", instruction, mem_word(32'h100));
        end
        repeat (6) tick();

        // Redirect while stalled with a full queue.
        apply_reset();
        lat   = 1;
        stall = 1'b1;
        reset = 1'b0;
        repeat (6) tick();
        @(negedge clock);
        check("full_before_branch", 32'(instr_valid), 32'd1);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        @(negedge clock);
        check("flushed", 32'(instr_valid), 32'd0);
        wait_valid("timeout_branch_full", seen);
        if (seen) check("flush_target_pc", instr_pc, 32'h200);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
